spram_ctrl: RTL and testbench
=============================

// Module: spram_ctrl
// PURPOSE
//  Initiator side of one SP256K single-port RAM (16K x 16): arbitrates a byte-wide CPU port (A)
//  and a 16-bit read-only video fetch port (B) onto the SPRAM pins.
//  Generates byte-lane write masks and returns read data.
//  Drops the macro into standby after an idle period and wakes it on demand.
//  Sits between the CPU/VERA bus fabric and the SP256K primitive.
// PARAMETERS
//  RR_ARB       1   1: round-robin between A and B; 0: fixed priority, A always wins
//  IDLE_CYCLES  64  consecutive no-grant cycles before STANDBY; 0 disables standby entirely
//  WAKE_CYCLES  3   cycles spent in WAKE, with STDBY low, before acks resume (must be >=1)
// PORTS
//  clk          in   1   sole clock; SPRAM CK is driven from the same net
//  rst          in   1   synchronous, active-high reset
//  a_req        in   1   port A request; a_addr/a_wr/a_wdata held stable until a_ack
//  a_addr       in   15  byte address; [14:1] = SPRAM word, [0] = byte lane
//  a_wr         in   1   1 = byte write, 0 = byte read
//  a_wdata      in   8   write byte
//  a_ack        out  1   combinational one-cycle accept pulse
//  a_rdata      out  8   read byte, valid while a_rvalid
//  a_rvalid     out  1   one-cycle read-data strobe
//  b_req        in   1   port B read request; b_addr held stable until b_ack
//  b_addr       in   14  word address
//  b_ack        out  1   combinational one-cycle accept pulse
//  b_rdata      out  16  read word, valid while b_rvalid
//  b_rvalid     out  1   one-cycle read-data strobe
//  sp_ad        out  14  SPRAM AD
//  sp_di        out  16  SPRAM DI
//  sp_maskwe    out  4   SPRAM MASKWE (nibble enables)
//  sp_we        out  1   SPRAM WE
//  sp_cs        out  1   SPRAM CS
//  sp_stdby     out  1   SPRAM STDBY
//  sp_sleep     out  1   SPRAM SLEEP; tied 0
//  sp_pwroff_n  out  1   SPRAM PWROFF_N; tied 1
//  sp_do        in   16  SPRAM DO; registered, valid the cycle after CS
// BEHAVIOUR
//  States and transitions:
//   - ACTIVE: acks allowed.
//   - ACTIVE->STANDBY: idle_cnt reaches IDLE_CYCLES with no request pending that cycle.
//   - STANDBY: sp_stdby=1, no acks.
//   - STANDBY->WAKE: any a_req|b_req.
//   - WAKE: sp_stdby=0, no acks, wake_cnt counts WAKE_CYCLES.
//   - WAKE->ACTIVE: wake_cnt expires.
//  Idle counter: counts cycles without a grant while in ACTIVE; cleared on any grant.
//   - Saturates at IDLE_CYCLES.
//   - A request in the same cycle the threshold is reached wins: that request is granted, counter clears.
//  Grant, ACTIVE only:
//   - One of a_ack/b_ack per cycle, never both.
//   - RR_ARB=1: on a collision, grant the port not granted last.
//   - RR_ARB=0: A always wins.
//   - Back-to-back grants every cycle are legal.
//  Issue cycle (the ack cycle), SPRAM pins driven combinationally:
//   - sp_cs=1; sp_ad = granted address (a_addr[14:1] or b_addr).
//   - A write: sp_we=1, sp_di={a_wdata,a_wdata}.
//   - A write mask: sp_maskwe=4'b0011 if a_addr[0]=0, 4'b1100 if a_addr[0]=1.
//   - Reads: sp_we=0, sp_maskwe=0.
//   - No grant: sp_cs=0, sp_we=0, sp_maskwe=0.
//  Read return, latency exactly 1:
//   - Cycle after an A read ack: a_rvalid=1, a_rdata = lane sp_do[15:8] or sp_do[7:0], per the registered a_addr[0].
//   - Cycle after a B read ack: b_rvalid=1, b_rdata=sp_do.
//   - A writes produce no rvalid.
//   - rdata registers hold their value between strobes.
//  Reset:
//   - State=ACTIVE, idle_cnt=0, last-grant=B (so A wins the first collision).
//   - All acks, rvalids, rdata, sp_cs/we/maskwe/stdby = 0; sp_pwroff_n=1.
//   - A read acked the cycle before rst produces no rvalid.
//  sp_ad/sp_di are don't-care when sp_cs=0 but must never be X after reset (drive 0).
// TESTING
//  - Write A addr 0x0005 data 0xAB -> sp_maskwe=1100, sp_di=ABAB, sp_ad=0x0002.
//      Then read 0x0005 -> a_rdata=0xAB one cycle after ack; read 0x0004 -> prior low byte unchanged.
//  - a_req and b_req held together 6 cycles, RR_ARB=1 -> acks alternate A,B,A,B,A,B.
//      Same with RR_ARB=0 -> A acked every cycle, b_ack stays 0.
//  - IDLE_CYCLES=4, no requests -> sp_stdby rises after 4 idle cycles.
//      Then a_req -> sp_stdby falls next cycle; a_ack arrives after WAKE_CYCLES=3 cycles of WAKE.
//  - a_req asserted in the exact cycle idle_cnt hits threshold -> acked, no standby entry.
//  - B read word 0x1234 (preloaded 0xBEEF) -> b_rvalid 1 cycle after b_ack with 0xBEEF.
//      Assert rst in the b_rvalid-pending cycle -> no b_rvalid, all outputs at reset values.
//  - Back-to-back A reads of 0x0000..0x0007 -> 8 consecutive acks, 8 consecutive rvalids, correct bytes.

Source files
------------

// File: rtl/spram_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// spram_ctrl - arbitrates a byte CPU port and a word video port onto one SP256K
// Revision: 1.0
// -----------------------------------------------------------------------------
module spram_ctrl #(
  parameter int RR_ARB      = 1,
  parameter int IDLE_CYCLES = 64,
  parameter int WAKE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic [14:0] a_addr,
  input  logic        a_wr,
  input  logic [7:0]  a_wdata,
  output logic        a_ack,
  output logic [7:0]  a_rdata,
  output logic        a_rvalid,
  input  logic        b_req,
  input  logic [13:0] b_addr,
  output logic        b_ack,
  output logic [15:0] b_rdata,
  output logic        b_rvalid,
  output logic [13:0] sp_ad,
  output logic [15:0] sp_di,
  output logic [3:0]  sp_maskwe,
  output logic        sp_we,
  output logic        sp_cs,
  output logic        sp_stdby,
  output logic        sp_sleep,
  output logic        sp_pwroff_n,
  input  logic [15:0] sp_do
);

  localparam int c_idle_w = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam int c_wake_w = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [c_idle_w-1:0] c_idle_max  = c_idle_w'(IDLE_CYCLES);
  localparam logic [c_wake_w-1:0] c_wake_last = c_wake_w'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_STANDBY = 2'd1,
    ST_WAKE    = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_idle_w-1:0] r_idle_cnt;
  logic [c_wake_w-1:0] r_wake_cnt;
  logic                r_last_b;
  logic                r_stdby;
  logic                r_a_pend;
  logic                r_a_lane;
  logic                r_b_pend;
  logic [7:0]          r_a_hold;
  logic [15:0]         r_b_hold;

  logic                w_grant_a;
  logic                w_grant_b;
  logic [7:0]          w_a_lane_data;
  logic [c_idle_w-1:0] w_idle_inc;

  // r_last_b set means B won last, so A takes the next collision
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (!rst && r_state == ST_ACTIVE) begin
      if (a_req && b_req) begin
        if (RR_ARB != 0 && !r_last_b) w_grant_b = 1'b1;
        else                          w_grant_a = 1'b1;
      end else begin
        w_grant_a = a_req;
        w_grant_b = b_req;
      end
    end
  end

  assign a_ack       = w_grant_a;
  assign b_ack       = w_grant_b;
  assign sp_cs       = w_grant_a | w_grant_b;
  assign sp_we       = w_grant_a & a_wr;
  assign sp_maskwe   = sp_we ? (a_addr[0] ? 4'b1100 : 4'b0011) : 4'b0000;
  assign sp_ad       = w_grant_a ? a_addr[14:1] : (w_grant_b ? b_addr : 14'd0);
  assign sp_di       = sp_we ? {a_wdata, a_wdata} : 16'd0;
  assign sp_stdby    = r_stdby;
  assign sp_sleep    = 1'b0;
  assign sp_pwroff_n = 1'b1;

  assign w_a_lane_data = r_a_lane ? sp_do[15:8] : sp_do[7:0];
  assign w_idle_inc    = r_idle_cnt + 1'b1;

  // Return path is live during the strobe cycle and falls back to the held copy
  assign a_rvalid = r_a_pend & ~rst;
  assign b_rvalid = r_b_pend & ~rst;
  assign a_rdata  = rst ? 8'd0  : (r_a_pend ? w_a_lane_data : r_a_hold);
  assign b_rdata  = rst ? 16'd0 : (r_b_pend ? sp_do : r_b_hold);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_ACTIVE;
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
      r_last_b   <= 1'b1;
      r_stdby    <= 1'b0;
      r_a_pend   <= 1'b0;
      r_a_lane   <= 1'b0;
      r_b_pend   <= 1'b0;
      r_a_hold   <= 8'd0;
      r_b_hold   <= 16'd0;
    end else begin
      r_a_pend <= w_grant_a & ~a_wr;
      r_b_pend <= w_grant_b;
      if (w_grant_a)             r_a_lane <= a_addr[0];
      if (r_a_pend)              r_a_hold <= w_a_lane_data;
      if (r_b_pend)              r_b_hold <= sp_do;
      if (w_grant_a | w_grant_b) r_last_b <= w_grant_b;

      case (r_state)
        ST_ACTIVE: begin
          // Any request in ACTIVE is granted, so no grant also means no request
          if (w_grant_a | w_grant_b) begin
            r_idle_cnt <= '0;
          end else if (IDLE_CYCLES != 0) begin
            r_idle_cnt <= w_idle_inc;
            if (w_idle_inc == c_idle_max) begin
              r_state <= ST_STANDBY;
              r_stdby <= 1'b1;
            end
          end
        end
        ST_STANDBY: begin
          if (a_req | b_req) begin
            r_state    <= ST_WAKE;
            r_stdby    <= 1'b0;
            r_wake_cnt <= '0;
          end
        end
        ST_WAKE: begin
          if (r_wake_cnt == c_wake_last) begin
            r_state    <= ST_ACTIVE;
            r_idle_cnt <= '0;
          end else begin
            r_wake_cnt <= r_wake_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_ACTIVE;
          r_stdby <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spram_ctrl.sv
`default_nettype none
// Testbench for spram_ctrl: SP256K behavioural model plus queue scoreboard.
module tb_spram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Round-robin instance with a short idle threshold
  logic        a_req = 1'b0, a_wr = 1'b0, b_req = 1'b0;
  logic [14:0] a_addr = '0;
  logic [7:0]  a_wdata = '0;
  logic [13:0] b_addr = '0;
  logic        a_ack, a_rvalid, b_ack, b_rvalid;
  logic [7:0]  a_rdata;
  logic [15:0] b_rdata;
  logic [13:0] sp_ad;
  logic [15:0] sp_di, sp_do;
  logic [3:0]  sp_maskwe;
  logic        sp_we, sp_cs, sp_stdby, sp_sleep, sp_pwroff_n;

  spram_ctrl #(.RR_ARB(1), .IDLE_CYCLES(4), .WAKE_CYCLES(3)) u_rr (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_wr(a_wr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .sp_ad(sp_ad), .sp_di(sp_di), .sp_maskwe(sp_maskwe), .sp_we(sp_we), .sp_cs(sp_cs),
    .sp_stdby(sp_stdby), .sp_sleep(sp_sleep), .sp_pwroff_n(sp_pwroff_n), .sp_do(sp_do)
  );

  // Fixed-priority instance, standby disabled
  logic        f_a_req = 1'b0, f_b_req = 1'b0;
  logic [14:0] f_a_addr = '0;
  logic [13:0] f_b_addr = '0;
  logic        f_a_ack, f_a_rvalid, f_b_ack, f_b_rvalid;
  logic [7:0]  f_a_rdata;
  logic [15:0] f_b_rdata;
  logic [13:0] f_sp_ad;
  logic [15:0] f_sp_di;
  logic [15:0] f_sp_do = 16'h0000;
  logic [3:0]  f_sp_maskwe;
  logic        f_sp_we, f_sp_cs, f_sp_stdby, f_sp_sleep, f_sp_pwroff_n;

  spram_ctrl #(.RR_ARB(0), .IDLE_CYCLES(0), .WAKE_CYCLES(3)) u_fp (
    .clk(clk), .rst(rst),
    .a_req(f_a_req), .a_addr(f_a_addr), .a_wr(1'b0), .a_wdata(8'h00),
    .a_ack(f_a_ack), .a_rdata(f_a_rdata), .a_rvalid(f_a_rvalid),
    .b_req(f_b_req), .b_addr(f_b_addr), .b_ack(f_b_ack), .b_rdata(f_b_rdata), .b_rvalid(f_b_rvalid),
    .sp_ad(f_sp_ad), .sp_di(f_sp_di), .sp_maskwe(f_sp_maskwe), .sp_we(f_sp_we), .sp_cs(f_sp_cs),
    .sp_stdby(f_sp_stdby), .sp_sleep(f_sp_sleep), .sp_pwroff_n(f_sp_pwroff_n), .sp_do(f_sp_do)
  );

  // SP256K model: nibble-masked writes, registered read data
  logic [15:0] mem [0:16383];
  bit          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 8; i++) mem[i] <= {8'h11 + 8'(2 * i), 8'h10 + 8'(2 * i)};
      mem[14'h1234] <= 16'hBEEF;
      mem_ready     <= 1'b1;
    end else if (sp_cs) begin
      if (sp_we) begin
        for (int k = 0; k < 4; k++)
          if (sp_maskwe[k]) mem[sp_ad][4*k +: 4] <= sp_di[4*k +: 4];
      end else begin
        sp_do <= mem[sp_ad];
      end
    end
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  a_exp [$];
  logic [15:0] b_exp [$];
  logic [7:0]  shadow [0:15];

  task automatic wait_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_ack) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_b(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_ack) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({a_ack, b_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_acks: got %b expected 00", {a_ack, b_ack}); end
    n_checks++; if ({a_rvalid, b_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 00", {a_rvalid, b_rvalid}); end
    n_checks++; if ({a_rdata, b_rdata} !== 24'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 000000", {a_rdata, b_rdata}); end
    n_checks++; if ({sp_cs, sp_we, sp_maskwe, sp_stdby} !== 7'b0) begin n_fail++; $display("FAIL reset_pins: got %b expected 0000000", {sp_cs, sp_we, sp_maskwe, sp_stdby}); end
    n_checks++; if ({sp_pwroff_n, sp_sleep} !== 2'b10) begin n_fail++; $display("FAIL reset_power: got %b expected 10", {sp_pwroff_n, sp_sleep}); end
    n_checks++; if ({sp_ad, sp_di} !== 30'h0) begin n_fail++; $display("FAIL reset_ad_di: got %h expected 0", {sp_ad, sp_di}); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_rr_collision();
    logic exp_a;
    a_req = 1'b1; a_wr = 1'b1; a_addr = 15'h0100; a_wdata = 8'h5A;
    b_req = 1'b1; b_addr = 14'h1234;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_a = (i % 2 == 0);
      n_checks++;
      if (a_ack !== exp_a || b_ack !== !exp_a) begin
        n_fail++; $display("FAIL rr_alternate[%0d]: got a=%b b=%b expected a=%b b=%b", i, a_ack, b_ack, exp_a, !exp_a);
      end
      if (b_ack) b_exp.push_back(16'hBEEF);
      if (b_rvalid) begin
        n_checks++;
        if (b_exp.size() == 0 || b_rdata !== b_exp[0]) begin n_fail++; $display("FAIL rr_b_rdata: got %h expected %h", b_rdata, (b_exp.size() != 0) ? b_exp[0] : 16'hxxxx); end
        if (b_exp.size() != 0) void'(b_exp.pop_front());
      end
      @(posedge clk); #1;
    end
    a_req = 1'b0; a_wr = 1'b0; b_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (b_rvalid !== 1'b1 || b_exp.size() != 1 || b_rdata !== b_exp[0]) begin
      n_fail++; $display("FAIL rr_b_drain: got rvalid=%b data=%h expected rvalid=1 data=beef", b_rvalid, b_rdata);
    end
    b_exp.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_standby();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (sp_stdby !== 1'b0) begin n_fail++; $display("FAIL stdby_early[%0d]: got %b expected 0", i, sp_stdby); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++; if (sp_stdby !== 1'b1) begin n_fail++; $display("FAIL stdby_enter: got %b expected 1", sp_stdby); end
    @(posedge clk); #1;
    a_req = 1'b1; a_wr = 1'b1; a_addr = 15'h0100; a_wdata = 8'h5A;
    @(negedge clk);
    n_checks++; if (a_ack !== 1'b0) begin n_fail++; $display("FAIL stdby_no_ack: got %b expected 0", a_ack); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++; if (sp_stdby !== 1'b0) begin n_fail++; $display("FAIL wake_stdby[%0d]: got %b expected 0", i, sp_stdby); end
      n_checks++; if (a_ack !== 1'b0) begin n_fail++; $display("FAIL wake_no_ack[%0d]: got %b expected 0", i, a_ack); end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (a_ack !== 1'b1) begin n_fail++; $display("FAIL wake_ack: got %b expected 1", a_ack); end
    @(posedge clk); #1;
    a_req = 1'b0; a_wr = 1'b0;
  endtask

  task automatic test_threshold();
    repeat (3) begin @(posedge clk); #1; end
    a_req = 1'b1; a_wr = 1'b1; a_addr = 15'h0100; a_wdata = 8'h5A;
    @(negedge clk);
    n_checks++; if (a_ack !== 1'b1) begin n_fail++; $display("FAIL threshold_ack: got %b expected 1", a_ack); end
    @(posedge clk); #1;
    a_req = 1'b0; a_wr = 1'b0;
    @(negedge clk);
    n_checks++; if (sp_stdby !== 1'b0) begin n_fail++; $display("FAIL threshold_no_stdby: got %b expected 0", sp_stdby); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    bit ok;
    a_req = 1'b1; a_wr = 1'b1; a_addr = 15'h0005; a_wdata = 8'hAB;
    wait_a(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL write_ack: got timeout expected ack"); end
    n_checks++; if (sp_maskwe !== 4'b1100) begin n_fail++; $display("FAIL write_mask: got %b expected 1100", sp_maskwe); end
    n_checks++; if (sp_di !== 16'hABAB) begin n_fail++; $display("FAIL write_di: got %h expected abab", sp_di); end
    n_checks++; if (sp_ad !== 14'h0002 || sp_we !== 1'b1) begin n_fail++; $display("FAIL write_ad_we: got ad=%h we=%b expected ad=0002 we=1", sp_ad, sp_we); end
    shadow[5] = 8'hAB;
    @(posedge clk); #1;
    a_req = 1'b0; a_wr = 1'b0;
    @(negedge clk);
    n_checks++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL write_no_rvalid: got %b expected 0", a_rvalid); end
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      a_req = 1'b1; a_addr = (r == 0) ? 15'h0005 : 15'h0004;
      wait_a(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL read_ack[%0d]: got timeout expected ack", r); end
      n_checks++; if ({sp_we, sp_maskwe} !== 5'b0) begin n_fail++; $display("FAIL read_pins[%0d]: got %b expected 00000", r, {sp_we, sp_maskwe}); end
      a_exp.push_back(shadow[a_addr[3:0]]);
      @(posedge clk); #1;
      a_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if (a_rvalid !== 1'b1 || a_exp.size() == 0 || a_rdata !== a_exp[0]) begin
        n_fail++; $display("FAIL read_data[%0d]: got rvalid=%b data=%h expected rvalid=1 data=%h", r, a_rvalid, a_rdata, shadow[a_addr[3:0]]);
      end
      if (a_exp.size() != 0) void'(a_exp.pop_front());
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (a_rvalid !== 1'b0 || a_rdata !== shadow[a_addr[3:0]]) begin
        n_fail++; $display("FAIL read_hold[%0d]: got rvalid=%b data=%h expected rvalid=0 data=%h", r, a_rvalid, a_rdata, shadow[a_addr[3:0]]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_b_read_reset();
    bit ok;
    b_req = 1'b1; b_addr = 14'h1234;
    wait_b(ok);
    n_checks++; if (!ok || sp_ad !== 14'h1234) begin n_fail++; $display("FAIL b_ack: got ok=%b ad=%h expected ok=1 ad=1234", ok, sp_ad); end
    b_exp.push_back(16'hBEEF);
    @(posedge clk); #1;
    b_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (b_rvalid !== 1'b1 || b_exp.size() == 0 || b_rdata !== b_exp[0]) begin
      n_fail++; $display("FAIL b_read: got rvalid=%b data=%h expected rvalid=1 data=beef", b_rvalid, b_rdata);
    end
    if (b_exp.size() != 0) void'(b_exp.pop_front());
    @(posedge clk); #1;
    b_req = 1'b1;
    wait_b(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b_ack2: got timeout expected ack"); end
    @(posedge clk); #1;
    b_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    n_checks++; if (b_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_kills_rvalid: got %b expected 0", b_rvalid); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if ({a_rvalid, b_rvalid, a_ack, b_ack} !== 4'b0) begin n_fail++; $display("FAIL rst_strobes: got %b expected 0000", {a_rvalid, b_rvalid, a_ack, b_ack}); end
    n_checks++; if ({a_rdata, b_rdata} !== 24'h0) begin n_fail++; $display("FAIL rst_rdata: got %h expected 000000", {a_rdata, b_rdata}); end
    n_checks++; if ({sp_cs, sp_we, sp_maskwe, sp_stdby, sp_pwroff_n} !== 8'b00000001) begin n_fail++; $display("FAIL rst_pins: got %b expected 00000001", {sp_cs, sp_we, sp_maskwe, sp_stdby, sp_pwroff_n}); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acks = 0, rvs = 0, first_ack = -1, last_ack = -1, first_rv = -1, last_rv = -1;
    bit acked;
    a_req = 1'b1; a_wr = 1'b0; a_addr = 15'h0000;
    for (int cyc = 0; cyc < 40 && rvs < 8; cyc++) begin
      @(negedge clk);
      acked = a_ack;
      if (a_rvalid) begin
        n_checks++;
        if (a_exp.size() == 0 || a_rdata !== a_exp[0]) begin
          n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", rvs, a_rdata, (a_exp.size() != 0) ? a_exp[0] : 8'hxx);
        end
        if (a_exp.size() != 0) void'(a_exp.pop_front());
        if (first_rv < 0) first_rv = cyc;
        last_rv = cyc; rvs++;
      end
      if (acked) begin
        a_exp.push_back(shadow[a_addr[3:0]]);
        if (first_ack < 0) first_ack = cyc;
        last_ack = cyc; acks++;
      end
      @(posedge clk); #1;
      if (acked) begin
        if (a_addr == 15'h0007) a_req = 1'b0;
        else a_addr = a_addr + 15'd1;
      end
    end
    a_req = 1'b0;
    n_checks++; if (acks != 8 || rvs != 8) begin n_fail++; $display("FAIL b2b_counts: got acks=%0d rvalids=%0d expected 8/8", acks, rvs); end
    n_checks++; if (last_ack - first_ack != 7) begin n_fail++; $display("FAIL b2b_ack_span: got %0d expected 7", last_ack - first_ack); end
    n_checks++; if (last_rv - first_rv != 7 || first_rv != first_ack + 1) begin n_fail++; $display("FAIL b2b_rv_span: got span=%0d lag=%0d expected 7/1", last_rv - first_rv, first_rv - first_ack); end
  endtask

  task automatic test_fixed_priority();
    @(posedge clk); #1;
    f_a_req = 1'b1; f_b_req = 1'b1; f_a_addr = 15'h0002; f_b_addr = 14'h0003;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++; if (f_a_ack !== 1'b1) begin n_fail++; $display("FAIL fp_a_ack[%0d]: got %b expected 1", i, f_a_ack); end
      n_checks++; if (f_b_ack !== 1'b0) begin n_fail++; $display("FAIL fp_b_ack[%0d]: got %b expected 0", i, f_b_ack); end
      @(posedge clk); #1;
    end
    f_a_req = 1'b0; f_b_req = 1'b0;
  endtask

  initial begin
    for (int n = 0; n < 16; n++) shadow[n] = 8'h10 + 8'(n);
    test_reset();
    test_rr_collision();
    test_standby();
    test_threshold();
    test_write_read();
    test_b_read_reset();
    test_back_to_back();
    test_fixed_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
